// File: rtl/cla_serial_seq.sv
// cla_serial_seq: WIDTH-bit add/sub built by iterating one 4-bit carry-lookahead slice, LS nibble first.
module cla_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [IW+1:0]    sh;
    logic [3:0]       an, bn, p, g, c, ns;

    always_comb begin
        sh = {idx_q, 2'b00};
        an = a_q[sh +: 4];
        bn = b_q[sh +: 4];
        p  = an ^ bn;
        g  = an & bn;
        // Fully expanded lookahead: every carry depends only on g/p and the incoming carry.
        c[0] = g[0] | (p[0] & carry_q);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        ns = p ^ {c[2:0], carry_q};
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            sum_d[sh +: 4] = ns;
            carry_d = c[3];
            if (idx_q == LAST) begin
                state_d = DONE;
                cout_d  = c[3];
                ovf_d   = c[3] ^ c[2];
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (start) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub | cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_serial_seq.sv
// tb_cla_serial_seq: directed checks of the serial CLA add/sub on 16-bit and 4-bit instances.
module tb_cla_serial_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;
    logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_serial_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_serial_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: accept, four busy cycles with operands scrambled, one done cycle, back to idle.
    task automatic run_op(input string tag, input logic s, input logic ci, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] es, input logic ec, input logic eo);
        sub = s; cin = ci; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~s; cin = ~ci;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 1);
            chk({tag, "_nodone"}, {31'd0, done}, 0);
            tick();
        end
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_busy_off"}, {31'd0, busy}, 0);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
        chk({tag, "_sum_hold"}, {16'd0, sum}, {16'd0, es});
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sum", {16'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        tick();
        rst = 1'b0;
        tick();
        run_op("add_wrap", 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0);
        run_op("sub_borrow", 1, 0, 16'h0005, 16'h0007, 16'hFFFE, 0, 0);
        run_op("sub_ovf", 1, 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1);
        run_op("add_cin_ovf", 0, 1, 16'h7FFE, 16'h0001, 16'h8000, 0, 1);
        run_op("add_plain", 0, 0, 16'h1234, 16'h4321, 16'h5555, 0, 0);
        // Start held high: operands changed mid-run must not disturb the first result.
        sub = 0; cin = 0; a = 16'h1234; b = 16'h4321; start = 1'b1;
        tick();
        a = 16'h7FFE; b = 16'h0001; cin = 1;
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("b2b_done_c%0d", c), {31'd0, done}, {31'd0, c % 5 == 0});
            chk($sformatf("b2b_busy_c%0d", c), {31'd0, busy}, {31'd0, c % 5 != 0});
            if (c == 5) chk("b2b_sum1", {16'd0, sum}, 32'h5555);
            if (c == 10) begin
                chk("b2b_sum2", {16'd0, sum}, 32'h8000);
                chk("b2b_ovf2", {31'd0, ovf}, 1);
            end
            if (c == 15) start = 1'b0;
            tick();
        end
        chk("b2b_idle_done", {31'd0, done}, 0);
        chk("b2b_idle_busy", {31'd0, busy}, 0);
        // Async reset in the second RUN cycle, when nibble 0 of 0x1111+0x1111 is already in sum.
        sub = 0; cin = 0; a = 16'h1111; b = 16'h1111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_partial", {16'd0, sum}, 32'h0002);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_sum", {16'd0, sum}, 0);
        chk("arst_cout", {31'd0, cout}, 0);
        chk("arst_ovf", {31'd0, ovf}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("arst_no_done", {31'd0, done}, 0);
            tick();
        end
        run_op("post_rst", 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0);
        // Single-nibble instance: one RUN cycle, then done.
        a4 = 4'h9; b4 = 4'h8; sub4 = 0; cin4 = 0; start4 = 1'b1;
        tick();
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        chk("w4_busy", {31'd0, busy4}, 1);
        chk("w4_nodone", {31'd0, done4}, 0);
        tick();
        chk("w4_done", {31'd0, done4}, 1);
        chk("w4_sum", {28'd0, sum4}, 32'h1);
        chk("w4_cout", {31'd0, cout4}, 1);
        chk("w4_ovf", {31'd0, ovf4}, 1);
        tick();
        chk("w4_done_pulse", {31'd0, done4}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
